// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller:
// FSM states, ALU control codes, op/cmd/cond codes and the ALU-decode function.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // arith: command produces meaningful C/V; no_write: result is discarded
  typedef struct packed {
    logic       legal;
    logic [2:0] ctrl;
    logic       arith;
    logic       no_write;
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(input logic [3:0] cmd, input logic s_bit,
                                          input logic ext_ops);
    alu_dec_t d;
    d = '0;
    case (cmd)
      CMD_ADD: begin d.legal = 1'b1; d.ctrl = ALU_ADD; d.arith = 1'b1; end
      CMD_SUB: begin d.legal = 1'b1; d.ctrl = ALU_SUB; d.arith = 1'b1; end
      CMD_AND: begin d.legal = 1'b1; d.ctrl = ALU_AND; end
      CMD_ORR: begin d.legal = 1'b1; d.ctrl = ALU_ORR; end
      CMD_CMP: begin d.legal = 1'b1; d.ctrl = ALU_SUB; d.arith = 1'b1; end
      CMD_EOR: begin d.legal = ext_ops; d.ctrl = ALU_EOR; end
      CMD_CMN: begin d.legal = ext_ops; d.ctrl = ALU_ADD; d.arith = 1'b1; end
      CMD_TST: begin d.legal = ext_ops; d.ctrl = ALU_AND; end
      CMD_MOV: begin d.legal = ext_ops; d.ctrl = ALU_MOV; end
      default: d = '0;
    endcase
    d.no_write = (cmd == CMD_CMP) || (cmd == CMD_CMN) || (cmd == CMD_TST) ||
                 ((cmd[3:2] == 2'b10) && s_bit);
    return d;
  endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// ARM condition-code evaluation against stored NZCV; the reserved code 1111 never passes.
module cond_check
  import multicycle_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM: Moore strobes/selects per state, conditional
// execution gating of every architectural write, and the stored NZCV flag register.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter bit EXT_OPS    = 1'b1,
  parameter bit COND_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr,
  input  logic [3:0]            alu_flags,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  adr_src,
  output logic                  mem_w,
  output logic                  reg_w,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0]            flags,
  output logic                  illegal,
  output logic [3:0]            state
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_instr_bits;

  assign cond  = instr[31:28];
  assign op    = instr[27:26];
  assign funct = instr[25:20];
  assign rd    = instr[15:12];
  assign unused_instr_bits = ^{instr[19:16], instr[11:0]};

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic     cond_raw, cond_pass, rd_is_pc;
  alu_dec_t dec;

  cond_check u_cond_check (
    .cond      (cond),
    .flags     (flags_q),
    .cond_pass (cond_raw)
  );

  assign cond_pass = COND_EN ? cond_raw : 1'b1;
  assign dec       = alu_decode(funct[4:1], funct[0], EXT_OPS);
  assign rd_is_pc  = (rd == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  logic       pc_write_c, ir_write_c, mem_w_c, reg_w_c;
  logic [2:0] alu_ctrl_c;

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    pc_write_c = 1'b0;
    ir_write_c = 1'b0;
    mem_w_c    = 1'b0;
    reg_w_c    = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    imm_src    = 2'b00;
    reg_src    = {op == OP_MEM, op == OP_BR};
    alu_ctrl_c = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // PC+8 is computed here so branches see the architectural PC
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = !dec.legal ? S_TRAP : (funct[5] ? S_EXECI : S_EXECR);
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        imm_src   = 2'b01;
        state_d   = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        pc_write_c = cond_pass & rd_is_pc;
        reg_w_c    = cond_pass & ~rd_is_pc;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w_c = cond_pass;
        state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b  = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_ctrl_c = dec.ctrl;
        // logical ops leave C/V untouched
        if (funct[0] && cond_pass)
          flags_d = {alu_flags[3:2], dec.arith ? alu_flags[1:0] : flags_q[1:0]};
        state_d = dec.no_write ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        pc_write_c = cond_pass & rd_is_pc;
        reg_w_c    = cond_pass & ~rd_is_pc;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        imm_src    = 2'b10;
        result_src = 2'b10;
        pc_write_c = cond_pass;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset holds the FSM in FETCH, whose strobes must not fire while rst_n is low
  assign pc_write = pc_write_c & rst_n;
  assign ir_write = ir_write_c & rst_n;
  assign mem_w    = mem_w_c & rst_n;
  assign reg_w    = reg_w_c & rst_n;

  always_comb begin
    alu_control      = '0;
    alu_control[2:0] = alu_ctrl_c;
  end

  assign flags = flags_q;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-instruction bench: stimulus pushes per-cycle expectations into a queue,
// a negedge monitor pops one per cycle and compares against the selected DUT.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [3:0]  alu_flags = 4'h0;

  logic       pc_write, ir_write, mem_w, reg_w, illegal;
  logic [2:0] alu_control;
  logic [3:0] flags, state;
  logic [9:0] unused_sel;

  logic       pc_write_x, ir_write_x, mem_w_x, reg_w_x, illegal_x;
  logic [3:0] alu_control_x;
  logic [3:0] flags_x, state_x;
  logic [9:0] unused_sel_x;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_flags(alu_flags),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(unused_sel[0]),
    .mem_w(mem_w), .reg_w(reg_w), .alu_src_a(unused_sel[1]),
    .alu_src_b(unused_sel[3:2]), .result_src(unused_sel[5:4]),
    .imm_src(unused_sel[7:6]), .reg_src(unused_sel[9:8]),
    .alu_control(alu_control), .flags(flags), .illegal(illegal), .state(state)
  );

  multicycle_controller #(.ALU_CTRL_W(4), .EXT_OPS(1'b0), .COND_EN(1'b1)) dut_x (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_flags(alu_flags),
    .pc_write(pc_write_x), .ir_write(ir_write_x), .adr_src(unused_sel_x[0]),
    .mem_w(mem_w_x), .reg_w(reg_w_x), .alu_src_a(unused_sel_x[1]),
    .alu_src_b(unused_sel_x[3:2]), .result_src(unused_sel_x[5:4]),
    .imm_src(unused_sel_x[7:6]), .reg_src(unused_sel_x[9:8]),
    .alu_control(alu_control_x), .flags(flags_x), .illegal(illegal_x), .state(state_x)
  );

  typedef struct {
    bit         sel;
    int         tag;
    logic [3:0] st;
    logic       pc;
    logic       ir;
    logic       rg;
    logic       mem;
    logic       ill;
    logic [3:0] alu;
    logic [3:0] flg;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // ir_write is expected exactly in a FETCH cycle outside reset, i.e. when FETCH also writes PC
  function automatic void push(input bit sel, input int tag, input logic [3:0] st,
                               input logic pc, input logic rg, input logic mem,
                               input logic ill, input logic [3:0] alu, input logic [3:0] flg);
    exp_t e;
    e.sel = sel; e.tag = tag; e.st = st; e.pc = pc; e.ir = (st == 4'd0) && pc;
    e.rg = rg; e.mem = mem; e.ill = ill; e.alu = alu; e.flg = flg;
    q.push_back(e);
  endfunction

  task automatic check_now(input int tag, input logic [31:0] g, input logic [31:0] w);
    n_checks++;
    if (g !== w) begin
      n_fail++;
      $display("FAIL immediate check %0d: got %h want %h", tag, g, w);
    end
  endtask

  exp_t        me;
  logic [16:0] got, want;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      got = me.sel ? {state_x, pc_write_x, ir_write_x, reg_w_x, mem_w_x, illegal_x,
                      alu_control_x, flags_x}
                   : {state, pc_write, ir_write, reg_w, mem_w, illegal,
                      1'b0, alu_control, flags};
      want = {me.st, me.pc, me.ir, me.rg, me.mem, me.ill, me.alu, me.flg};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL instr%0d dut%0d: got st=%0d pc=%b ir=%b rw=%b mw=%b ill=%b alu=%b flg=%b; want st=%0d pc=%b ir=%b rw=%b mw=%b ill=%b alu=%b flg=%b",
                 me.tag, me.sel, got[16:13], got[12], got[11], got[10], got[9], got[8],
                 got[7:4], got[3:0], want[16:13], want[12], want[11], want[10], want[9],
                 want[8], want[7:4], want[3:0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [3:0] af);
    instr = ins;
    alu_flags = af;
  endtask

  initial begin
    @(posedge clk); #1;
    check_now(100, {19'b0, state, pc_write, ir_write, reg_w, mem_w, illegal, flags},
              {19'b0, 4'd0, 5'b00000, 4'h0});
    push(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    step(1);
    rst_n = 1'b1;

    // 1: LDR R2,[R0]
    issue(32'hE590_2000, 4'h0);
    push(0, 1, 0, 1, 0, 0, 0, 4'h0, 4'h0); push(0, 1, 1, 0, 0, 0, 0, 4'h0, 4'h0);
    push(0, 1, 2, 0, 0, 0, 0, 4'h0, 4'h0); push(0, 1, 3, 0, 0, 0, 0, 4'h0, 4'h0);
    push(0, 1, 4, 0, 1, 0, 0, 4'h0, 4'h0);
    step(5);
    // 2: ADDS R1, alu flags 0110
    issue(32'hE090_1000, 4'b0110);
    push(0, 2, 0, 1, 0, 0, 0, 4'h0, 4'h0); push(0, 2, 1, 0, 0, 0, 0, 4'h0, 4'h0);
    push(0, 2, 6, 0, 0, 0, 0, 4'h0, 4'h0); push(0, 2, 8, 0, 1, 0, 0, 4'h0, 4'b0110);
    step(4);
    // 3: CMP, alu flags 0100 -> skips ALUWB
    issue(32'hE150_0000, 4'b0100);
    push(0, 3, 0, 1, 0, 0, 0, 4'h0, 4'b0110); push(0, 3, 1, 0, 0, 0, 0, 4'h0, 4'b0110);
    push(0, 3, 6, 0, 0, 0, 0, 4'h1, 4'b0110);
    step(3);
    // 4: BEQ taken
    issue(32'h0A00_0002, 4'h0);
    push(0, 4, 0, 1, 0, 0, 0, 4'h0, 4'b0100); push(0, 4, 1, 0, 0, 0, 0, 4'h0, 4'b0100);
    push(0, 4, 9, 1, 0, 0, 0, 4'h0, 4'b0100);
    step(3);
    // 5: BNE not taken
    issue(32'h1A00_0002, 4'h0);
    push(0, 5, 0, 1, 0, 0, 0, 4'h0, 4'b0100); push(0, 5, 1, 0, 0, 0, 0, 4'h0, 4'b0100);
    push(0, 5, 9, 0, 0, 0, 0, 4'h0, 4'b0100);
    step(3);
    // 6: ORRS imm, alu flags 1011 -> N,Z updated, C,V held
    issue(32'hE390_3000, 4'b1011);
    push(0, 6, 0, 1, 0, 0, 0, 4'h0, 4'b0100); push(0, 6, 1, 0, 0, 0, 0, 4'h0, 4'b0100);
    push(0, 6, 7, 0, 0, 0, 0, 4'h3, 4'b0100); push(0, 6, 8, 0, 1, 0, 0, 4'h0, 4'b1000);
    step(4);
    // 7: ADDSEQ with Z=0 -> same path, no writes, no flag update
    issue(32'h0090_4000, 4'b1111);
    push(0, 7, 0, 1, 0, 0, 0, 4'h0, 4'b1000); push(0, 7, 1, 0, 0, 0, 0, 4'h0, 4'b1000);
    push(0, 7, 6, 0, 0, 0, 0, 4'h0, 4'b1000); push(0, 7, 8, 0, 0, 0, 0, 4'h0, 4'b1000);
    step(4);
    // 8: STR
    issue(32'hE580_3000, 4'h0);
    push(0, 8, 0, 1, 0, 0, 0, 4'h0, 4'b1000); push(0, 8, 1, 0, 0, 0, 0, 4'h0, 4'b1000);
    push(0, 8, 2, 0, 0, 0, 0, 4'h0, 4'b1000); push(0, 8, 5, 0, 0, 1, 0, 4'h0, 4'b1000);
    step(4);
    // 9: LDR PC -> pc_write instead of reg_w
    issue(32'hE590_F000, 4'h0);
    push(0, 9, 0, 1, 0, 0, 0, 4'h0, 4'b1000); push(0, 9, 1, 0, 0, 0, 0, 4'h0, 4'b1000);
    push(0, 9, 2, 0, 0, 0, 0, 4'h0, 4'b1000); push(0, 9, 3, 0, 0, 0, 0, 4'h0, 4'b1000);
    push(0, 9, 4, 1, 0, 0, 0, 4'h0, 4'b1000);
    step(5);
    // 10: unsupported cmd 0011 -> TRAP
    issue(32'hE060_0000, 4'h0);
    push(0, 10, 0, 1, 0, 0, 0, 4'h0, 4'b1000); push(0, 10, 1, 0, 0, 0, 0, 4'h0, 4'b1000);
    push(0, 10, 10, 0, 0, 0, 1, 4'h0, 4'b1000);
    step(3);
    // 11: TST, alu flags 0111 -> flags 0100, no ALUWB
    issue(32'hE110_0000, 4'b0111);
    push(0, 11, 0, 1, 0, 0, 0, 4'h0, 4'b1000); push(0, 11, 1, 0, 0, 0, 0, 4'h0, 4'b1000);
    push(0, 11, 6, 0, 0, 0, 0, 4'h2, 4'b1000);
    step(3);
    // 12: EOR without S
    issue(32'hE020_5000, 4'b1111);
    push(0, 12, 0, 1, 0, 0, 0, 4'h0, 4'b0100); push(0, 12, 1, 0, 0, 0, 0, 4'h0, 4'b0100);
    push(0, 12, 6, 0, 0, 0, 0, 4'h4, 4'b0100); push(0, 12, 8, 0, 1, 0, 0, 4'h0, 4'b0100);
    step(4);
    // 13: MOV imm
    issue(32'hE3A0_6000, 4'h0);
    push(0, 13, 0, 1, 0, 0, 0, 4'h0, 4'b0100); push(0, 13, 1, 0, 0, 0, 0, 4'h0, 4'b0100);
    push(0, 13, 7, 0, 0, 0, 0, 4'h5, 4'b0100); push(0, 13, 8, 0, 1, 0, 0, 4'h0, 4'b0100);
    step(4);
    // 14: STR aborted by reset asserted inside MEMWR
    issue(32'hE580_3000, 4'h0);
    push(0, 14, 0, 1, 0, 0, 0, 4'h0, 4'b0100); push(0, 14, 1, 0, 0, 0, 0, 4'h0, 4'b0100);
    push(0, 14, 2, 0, 0, 0, 0, 4'h0, 4'b0100);
    step(3);
    #2;
    check_now(101, {27'b0, state, mem_w}, {27'b0, 4'd5, 1'b1});
    rst_n = 1'b0;
    #1;
    check_now(102, {23'b0, state, mem_w, flags}, {23'b0, 4'd0, 1'b0, 4'h0});
    push(0, 14, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    step(1);
    rst_n = 1'b1;

    // 15: EXT_OPS=0 instance: EOR traps
    issue(32'hE020_0000, 4'h0);
    push(1, 15, 0, 1, 0, 0, 0, 4'h0, 4'h0); push(1, 15, 1, 0, 0, 0, 0, 4'h0, 4'h0);
    push(1, 15, 10, 0, 0, 0, 1, 4'h0, 4'h0);
    step(3);
    // 16: op=11 traps the same way
    issue(32'hEC00_0000, 4'h0);
    push(1, 16, 0, 1, 0, 0, 0, 4'h0, 4'h0); push(1, 16, 1, 0, 0, 0, 0, 4'h0, 4'h0);
    push(1, 16, 10, 0, 0, 0, 1, 4'h0, 4'h0);
    step(3);
    // 17: ADD still decodes normally afterwards
    issue(32'hE080_1000, 4'b1111);
    push(1, 17, 0, 1, 0, 0, 0, 4'h0, 4'h0); push(1, 17, 1, 0, 0, 0, 0, 4'h0, 4'h0);
    push(1, 17, 6, 0, 0, 0, 0, 4'h0, 4'h0); push(1, 17, 8, 0, 1, 0, 0, 4'h0, 4'h0);
    step(4);

    step(1);
    check_now(103, q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
